// File: rtl/bfp_scaler.sv
`default_nettype none
//==============================================================================
// Module      : bfp_scaler
// Description : Block-floating-point pre-scaler for an FFT butterfly stage.
//               Measures per-frame headroom, shifts the next frame right by
//               0/1/2 bits and accumulates a saturating block exponent.
//               Optional feature macro: BFP_ROUND_EN (round half-up instead
//               of truncation).
// Revision    : 1.0 - initial release
//==============================================================================

`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module bfp_scaler #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int FRAME_LEN  = 64,
    parameter int EXP_WIDTH  = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  exp_clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_re,
    input  logic [DATA_WIDTH-1:0] in_im,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_re,
    output logic [DATA_WIDTH-1:0] out_im,
    output logic                  out_last,
    output logic [EXP_WIDTH-1:0]  out_exp,
    output logic                  frame_err
);

    localparam int                   c_cnt_w    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [c_cnt_w-1:0]   c_last_idx = c_cnt_w'(FRAME_LEN - 1);
    localparam logic [EXP_WIDTH-1:0] c_exp_max  = '1;

    logic [1:0]            r_shift;
    logic                  r_g1;
    logic                  r_g2;
    logic [EXP_WIDTH-1:0]  r_exp_acc;
    logic [c_cnt_w-1:0]    r_cnt;
    logic                  r_frame_err;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_re;
    logic [DATA_WIDTH-1:0] r_out_im;
    logic                  r_out_last;
    logic [EXP_WIDTH-1:0]  r_out_exp;

    logic                  w_accept;
    logic                  w_g1_all;
    logic                  w_g2_all;
    logic [1:0]            w_shift_next;
    logic [EXP_WIDTH:0]    w_exp_sum;
    logic [EXP_WIDTH-1:0]  w_exp_next;
    logic                  w_cnt_at_last;

    // Arithmetic right shift at DATA_WIDTH+1 bits; the extra bit absorbs the rounding carry.
    function automatic logic [DATA_WIDTH-1:0] f_scale(input logic [DATA_WIDTH-1:0] x,
                                                      input logic [1:0] sh);
        logic signed [DATA_WIDTH:0] v;
        v = $signed({x[DATA_WIDTH-1], x});
`ifdef BFP_ROUND_EN
        case (sh)
            2'd1:    v = v + $signed((DATA_WIDTH+1)'(1));
            2'd2:    v = v + $signed((DATA_WIDTH+1)'(2));
            default: v = v;
        endcase
`endif
        v = v >>> sh;
        return v[DATA_WIDTH-1:0];
    endfunction

    function automatic logic f_g1(input logic [DATA_WIDTH-1:0] x);
        return x[DATA_WIDTH-1] ^ x[DATA_WIDTH-2];
    endfunction

    function automatic logic f_g2(input logic [DATA_WIDTH-1:0] x);
        return (x[DATA_WIDTH-1:DATA_WIDTH-3] != 3'b000) && (x[DATA_WIDTH-1:DATA_WIDTH-3] != 3'b111);
    endfunction

    assign in_ready  = out_ready || !r_out_valid;
    assign w_accept  = in_valid && in_ready;

    assign w_g1_all  = r_g1 | f_g1(in_re) | f_g1(in_im);
    assign w_g2_all  = r_g2 | f_g2(in_re) | f_g2(in_im);
    assign w_shift_next = w_g1_all ? 2'd2 : (w_g2_all ? 2'd1 : 2'd0);

    assign w_exp_sum     = {1'b0, r_exp_acc} + (EXP_WIDTH+1)'(r_shift);
    assign w_exp_next    = w_exp_sum[EXP_WIDTH] ? c_exp_max : w_exp_sum[EXP_WIDTH-1:0];
    assign w_cnt_at_last = (r_cnt == c_last_idx);

    // Frame bookkeeping; exp_clear wins over a coincident frame end.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shift     <= 2'd0;
            r_g1        <= 1'b0;
            r_g2        <= 1'b0;
            r_exp_acc   <= '0;
            r_cnt       <= '0;
            r_frame_err <= 1'b0;
        end else begin
            if (exp_clear) begin
                r_shift   <= 2'd0;
                r_g1      <= 1'b0;
                r_g2      <= 1'b0;
                r_exp_acc <= '0;
                r_cnt     <= '0;
            end else if (w_accept) begin
                if (in_last) begin
                    r_shift   <= w_shift_next;
                    r_g1      <= 1'b0;
                    r_g2      <= 1'b0;
                    r_exp_acc <= w_exp_next;
                    r_cnt     <= '0;
                end else begin
                    r_g1      <= w_g1_all;
                    r_g2      <= w_g2_all;
                    r_cnt     <= w_cnt_at_last ? '0 : r_cnt + 1'b1;
                end
            end
            if (w_accept && (in_last != w_cnt_at_last)) begin
                r_frame_err <= 1'b1;
            end
        end
    end

    // Single output register; the beat carrying in_last still uses the old shift.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_re    <= '0;
            r_out_im    <= '0;
            r_out_last  <= 1'b0;
            r_out_exp   <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_re    <= f_scale(in_re, r_shift);
            r_out_im    <= f_scale(in_im, r_shift);
            r_out_last  <= in_last;
            r_out_exp   <= in_last ? w_exp_next : r_exp_acc;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_re    = r_out_re;
    assign out_im    = r_out_im;
    assign out_last  = r_out_last;
    assign out_exp   = r_out_exp;
    assign frame_err = r_frame_err;

endmodule

`default_nettype wire
